control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 118 +++++++++++
 tb/tb_control_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: two-state (RUN/HALT) instruction decoder and sequencer for a
// 16-bit datapath. Outputs are decoded combinationally; flags, illegal and icount are registered.
`default_nettype none

module control_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             carry,
    input  logic             go,
    output logic             s_skip,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we,
    output logic [2:0]       ALUOp,
    output logic             halted,
    output logic             flag_z,
    output logic             flag_c,
    output logic             illegal,
    output logic [CNT_W-1:0] icount
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t           state_q;
    logic             flag_z_q;
    logic             flag_c_q;
    logic             illegal_q;
    logic [CNT_W-1:0] icount_q;
    logic [CNT_W-1:0] icount_d;

    logic             dec_alu;
    logic             dec_halt;
    logic             dec_illegal;

    always_comb begin
        we          = 1'b0;
        s_inm       = 1'b0;
        s_skip      = 1'b0;
        s_inc       = 1'b1;
        ALUOp       = 3'b000;
        dec_alu     = 1'b0;
        dec_halt    = 1'b0;
        dec_illegal = 1'b0;
        if (!reset) begin
            s_inc = 1'b1;
        end else if (state_q == HALT) begin
            s_inc = go;
        end else begin
            casez (opcode)
                6'b0?????: begin
                    dec_alu = 1'b1;
                    we      = 1'b1;
                    ALUOp   = opcode[4:2];
                end
                6'b1000??: begin
                    we    = 1'b1;
                    s_inm = 1'b1;
                end
                6'b110000: s_inc = 1'b0;
                6'b110001: s_inc = ~flag_z_q;
                6'b110010: s_inc = flag_z_q;
                6'b110011: s_inc = ~flag_c_q;
                6'b110100: s_inc = flag_c_q;
                6'b111000: s_skip = flag_z_q;
                6'b111001: s_skip = flag_c_q;
                6'b111110: s_inc = 1'b1;
                6'b111100: begin
                    s_inc    = 1'b0;
                    dec_halt = 1'b1;
                end
                default:   dec_illegal = 1'b1;
            endcase
        end
    end

    // Saturating retired-instruction count; only advances while running.
    assign icount_d = (&icount_q) ? icount_q : icount_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
            illegal_q <= 1'b0;
            icount_q  <= '0;
        end else if (state_q == RUN) begin
            icount_q <= icount_d;
            if (dec_halt) begin
                state_q <= HALT;
            end
            if (dec_alu) begin
                flag_z_q <= zero;
                flag_c_q <= carry;
            end
            if (dec_illegal) begin
                illegal_q <= 1'b1;
            end
        end else if (go) begin
            state_q <= RUN;
        end
    end

    assign halted  = (state_q == HALT);
    assign flag_z  = flag_z_q;
    assign flag_c  = flag_c_q;
    assign illegal = illegal_q;
    assign icount  = icount_q;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: default-width instance plus a CNT_W=4
// instance sharing the same stimulus for the saturation check.
`default_nettype none

module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        zero, carry, go;

    logic        s_skip, s_inc, s_inm, we, halted, flag_z, flag_c, illegal;
    logic [2:0]  ALUOp;
    logic [15:0] icount;

    logic        s_skip4, s_inc4, s_inm4, we4, halted4, flag_z4, flag_c4, illegal4;
    logic [2:0]  ALUOp4;
    logic [3:0]  icount4;

    int vectors = 0;
    int errs    = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    control_unit #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .carry(carry), .go(go),
        .s_skip(s_skip), .s_inc(s_inc), .s_inm(s_inm), .we(we), .ALUOp(ALUOp),
        .halted(halted), .flag_z(flag_z), .flag_c(flag_c), .illegal(illegal), .icount(icount)
    );

    control_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .carry(carry), .go(go),
        .s_skip(s_skip4), .s_inc(s_inc4), .s_inm(s_inm4), .we(we4), .ALUOp(ALUOp4),
        .halted(halted4), .flag_z(flag_z4), .flag_c(flag_c4), .illegal(illegal4), .icount(icount4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the five datapath controls together: {we, s_inm, s_inc, s_skip, ALUOp}.
    task automatic check_ctl(input string tag, input logic [6:0] exp);
        check(tag, {25'd0, we, s_inm, s_inc, s_skip, ALUOp}, {25'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; opcode = 6'b101010; zero = 1'b1; carry = 1'b1; go = 1'b1;
        #22;
        check("rst_halted", halted, 0);
        check("rst_illegal", illegal, 0);
        check("rst_icount", icount, 0);
        check("rst_flags", {flag_z, flag_c}, 2'b00);
        check_ctl("rst_ctl", 7'b0010_000);

        // ALU op 000101 with zero=1, carry=0
        reset = 1'b1; opcode = 6'b000101; zero = 1'b1; carry = 1'b0; go = 1'b0;
        #1;
        check_ctl("alu_ctl", 7'b1010_001);
        tick(); exp_cnt = 1;
        check("alu_flags", {flag_z, flag_c}, 2'b10);
        check("alu_icount", icount, exp_cnt);

        // JZ / JNZ on latched flag_z=1, live zero toggled
        opcode = 6'b110001; zero = 1'b0; #1;
        check_ctl("jz_taken", 7'b0000_000);
        zero = 1'b1; #1;
        check_ctl("jz_taken_live1", 7'b0000_000);
        opcode = 6'b110010; zero = 1'b0; #1;
        check_ctl("jnz_not_taken", 7'b0010_000);
        opcode = 6'b110000; #1;
        check_ctl("j_always", 7'b0000_000);
        opcode = 6'b100011; #1;
        check_ctl("ldi", 7'b1110_000);

        // ALU 011100 sets carry, clears zero
        opcode = 6'b011100; zero = 1'b0; carry = 1'b1; #1;
        check_ctl("alu7_ctl", 7'b1010_111);
        tick(); exp_cnt++;
        check("alu7_flags", {flag_z, flag_c}, 2'b01);

        opcode = 6'b111001; carry = 1'b0; #1;
        check_ctl("skc_c1", 7'b0011_000);
        opcode = 6'b111000; #1;
        check_ctl("skz_z0", 7'b0010_000);
        opcode = 6'b110011; #1;
        check_ctl("jc_taken", 7'b0000_000);
        opcode = 6'b110100; #1;
        check_ctl("jnc_not_taken", 7'b0010_000);

        opcode = 6'b000000; zero = 1'b1; carry = 1'b0;
        tick(); exp_cnt++;
        opcode = 6'b111110; zero = 1'b0; carry = 1'b1; #1;
        check_ctl("nop_ctl", 7'b0010_000);
        tick(); exp_cnt++;
        check("flags_hold", {flag_z, flag_c}, 2'b10);
        opcode = 6'b111001; #1;
        check_ctl("skc_c0", 7'b0010_000);

        // HALT, five frozen cycles, then go
        opcode = 6'b111100; #1;
        check_ctl("halt_ctl", 7'b0000_000);
        tick(); exp_cnt++;
        check("halt_enter", halted, 1);
        check("halt_icount", icount, exp_cnt);
        opcode = 6'b000000; zero = 1'b0; carry = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_ctl("halt_idle_ctl", 7'b0000_000);
            tick();
            check("halt_frozen_cnt", icount, exp_cnt);
            check("halt_frozen_st", halted, 1);
        end
        check("halt_flags", {flag_z, flag_c}, 2'b10);
        go = 1'b1; #1;
        check_ctl("go_ctl", 7'b0010_000);
        tick();
        check("go_resume", halted, 0);
        check("go_icount", icount, exp_cnt);
        opcode = 6'b111110;
        tick(); exp_cnt++;
        check("go_in_run", halted, 0);
        go = 1'b0;

        // Illegal opcode: NOP outputs, sticky flag
        opcode = 6'b101010; #1;
        check_ctl("ill_ctl", 7'b0010_000);
        check("ill_before", illegal, 0);
        tick(); exp_cnt++;
        check("ill_set", illegal, 1);
        check("ill_icount", icount, exp_cnt);
        opcode = 6'b111110;
        tick();
        check("ill_sticky", illegal, 1);
        #2 reset = 1'b0; opcode = 6'b000101; #1;
        check("ill_async_clr", illegal, 0);
        check("rst_async_cnt", icount, 0);
        check("rst_async_flags", {flag_z, flag_c}, 2'b00);
        check_ctl("rst_forced_ctl", 7'b0010_000);

        // Reset while halted
        tick();
        reset = 1'b1; opcode = 6'b111100;
        tick();
        check("halt2_enter", halted, 1);
        #2 reset = 1'b0; #1;
        check("halt2_rst", halted, 0);

        // Saturation with the 4-bit instance
        tick();
        reset = 1'b1; opcode = 6'b111110;
        for (int i = 0; i < 20; i++) tick();
        check("sat_icount4", icount4, 4'hF);
        check("cnt_icount16", icount, 20);
        #2 reset = 1'b0; #1;
        check("sat_rst4", icount4, 0);
        check("sat_rst16", icount, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

`default_nettype wire
